// File: rtl/flags_ctx_stack.sv
// Status-flag register with per-bit write mask and a LIFO context stack used to
// save/restore flags across interrupt or call entry and exit.
module flags_ctx_stack #(
  parameter int FLAG_W    = 5,
  parameter int CARRY_BIT = 4,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FLAG_W-1:0]          wr_mask,
  input  logic [FLAG_W-1:0]          d_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [FLAG_W-1:0]          flags,
  output logic                       carry,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [FLAG_W-1:0]             flags_reg, flags_next;
  logic                          carry_reg;
  logic [CW-1:0]                 depth_reg, depth_next;
  logic                          ovf_reg, ovf_next;
  logic                          unf_reg, unf_next;
  logic [FLAG_W-1:0]             merged;
  logic [CW-1:0]                 top_idx;
  logic [FLAG_W-1:0]             top_val;
  logic                          stk_we;
  logic [CW-1:0]                 stk_addr;
  logic [DEPTH-1:0][FLAG_W-1:0]  stack_q;
  logic                          is_full, is_empty;

  assign is_full  = (depth_reg == CW'(DEPTH));
  assign is_empty = (depth_reg == '0);
  assign top_idx  = depth_reg - CW'(1);
  assign merged   = (flags_reg & ~wr_mask) | (d_in & wr_mask);

  // Top-of-stack read mux; only meaningful when the stack is not empty.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == top_idx) top_val = stack_q[i];
    end
  end

  always_comb begin
    flags_next = flags_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg & ~err_clr;
    unf_next   = unf_reg & ~err_clr;
    stk_we     = 1'b0;
    stk_addr   = depth_reg;
    if (push && pop) begin
      if (!is_empty) begin
        stk_we     = 1'b1;
        stk_addr   = top_idx;
        flags_next = top_val;
      end else begin
        unf_next = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        flags_next = top_val;
        depth_next = depth_reg - CW'(1);
      end else begin
        unf_next = 1'b1;
        if (wr_en) flags_next = merged;
      end
    end else if (push) begin
      // The saved context is the pre-write flag value.
      if (!is_full) begin
        stk_we     = 1'b1;
        stk_addr   = depth_reg;
        depth_next = depth_reg + CW'(1);
      end else begin
        ovf_next = 1'b1;
      end
      if (wr_en) flags_next = merged;
    end else if (wr_en) begin
      flags_next = merged;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [FLAG_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (stk_we && stk_addr == CW'(gi)) entry_reg <= flags_reg;
      end
      assign stack_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
      carry_reg <= 1'b0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      carry_reg <= flags_next[CARRY_BIT];
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign flags     = flags_reg;
  assign carry     = carry_reg;
  assign depth_cnt = depth_reg;
  assign full      = is_full;
  assign empty     = is_empty;
  assign ovf_err   = ovf_reg;
  assign unf_err   = unf_reg;

endmodule
